// File: rtl/seg_display_arbiter_if.sv
// Bundle between the value sources and the seven-segment display arbiter.
// Sources hold req[i] high while they want the display; grant[i] is the acknowledge.
interface seg_display_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Level handshake: req[i] is a sustained level (not a pulse); the arbiter answers with
    // a one-hot grant and the source keeps req[i] high for as long as it wants the display.
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*14-1:0] value;
    logic                  next_pulse;
    logic [NUM_REQ-1:0]    grant;
    logic [13:0]           displayed_number;
    logic                  blank;
    logic                  ovf;
    logic                  state_dbg;

    modport master (
        output req, value, next_pulse,
        input  grant, displayed_number, blank, ovf, state_dbg
    );

    modport slave (
        input  req, value, next_pulse,
        output grant, displayed_number, blank, ovf, state_dbg
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the 4-digit display between NUM_REQ value sources,
// with dwell timeout, next-button advance, blanking and 9999 saturation.
module seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNT_WIDTH   = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [13:0] MAX_DISP = 14'd9999;
    localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     ptr, ptr_n, win;
    logic [CNT_WIDTH-1:0] dwell, dwell_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [13:0]          raw, disp_n;
    logic                 ovf_n;

    // Scan ptr+1, ptr+2, ... with wrap; the nearest requester wins, so the current
    // owner (offset NUM_REQ) is only chosen when nobody else is asking.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
        logic [PTR_W-1:0] w;
        logic [PTR_W-1:0] idx;
        w = p;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(p) + k) % NUM_REQ);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= PTR_W'(NUM_REQ - 1);
            dwell <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            dwell <= dwell_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        dwell_n = dwell;
        win     = rr_pick(bus.req, ptr);
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n = SHOW;
                    ptr_n   = win;
                    dwell_n = '0;
                end
            end
            SHOW: begin
                if (!bus.req[ptr]) begin
                    dwell_n = '0;
                    if (|bus.req) ptr_n = win;
                    else          state_n = IDLE;
                end else if (bus.next_pulse || (dwell == DWELL_LAST)) begin
                    ptr_n   = win;
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming owner so grant and display change together.
    always_comb begin
        raw     = '0;
        grant_n = '0;
        disp_n  = '0;
        ovf_n   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ptr_n == PTR_W'(i)) raw = bus.value[14*i +: 14];
        end
        if (state_n == SHOW) begin
            grant_n = NUM_REQ'(1) << ptr_n;
            if (raw > MAX_DISP) begin
                disp_n = MAX_DISP;
                ovf_n  = 1'b1;
            end else begin
                disp_n = raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.grant            <= '0;
            bus.displayed_number <= '0;
            bus.blank            <= 1'b1;
            bus.ovf              <= 1'b0;
        end else begin
            bus.grant            <= grant_n;
            bus.displayed_number <= disp_n;
            bus.blank            <= (state_n == IDLE);
            bus.ovf              <= ovf_n;
        end
    end

    assign bus.state_dbg = state;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic, all cycles
// checked against a cycle-level behavioural model of the display-sharing rules.
module tb_seg_display_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int CW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_display_arbiter_if #(.NUM_REQ(N)) bus ();

    seg_display_arbiter #(
        .NUM_REQ(N), .HOLD_CYCLES(HOLD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the display, who owned it last, how many cycles it has shown.
    int          m_owner = -1;
    int          m_last  = N - 1;
    int          m_shown = 0;
    logic [13:0] vals [N];
    logic [3:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_val(input int i, input logic [13:0] v);
        vals[i] = v;
        bus.value[14*i +: 14] = v;
    endtask

    function automatic int next_owner(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_shown = 0;
    endfunction

    function automatic void take(input int w);
        m_owner = w;
        m_last  = w;
        m_shown = 1;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] r;
        r = bus.req;
        if (m_owner < 0) begin
            if (r != 0) take(next_owner(r));
        end else if (!r[m_owner]) begin
            if (r != 0) take(next_owner(r));
            else        model_reset_owner();
        end else if (bus.next_pulse || m_shown == HOLD) begin
            take(next_owner(r));
        end else begin
            m_shown++;
        end
    endfunction

    function automatic void model_reset_owner();
        m_owner = -1;
        m_shown = 0;
    endfunction

    task automatic check_all();
        int raw;
        if (m_owner < 0) begin
            chk("grant", bus.grant, 0);
            chk("disp", bus.displayed_number, 0);
            chk("blank", bus.blank, 1);
            chk("ovf", bus.ovf, 0);
        end else begin
            raw = vals[m_owner];
            chk("grant", bus.grant, 1 << m_owner);
            chk("disp", bus.displayed_number, (raw > 9999) ? 9999 : raw);
            chk("blank", bus.blank, 0);
            chk("ovf", bus.ovf, (raw > 9999) ? 1 : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] target, input int max);
        for (int i = 0; i < max && bus.grant !== target; i++) step();
        chk(tag, bus.grant, target);
    endtask

    initial begin
        int run;
        logic [N-1:0] prev;

        bus.req        = '0;
        bus.value      = '0;
        bus.next_pulse = 1'b0;
        for (int i = 0; i < N; i++) vals[i] = '0;

        // Reset and first grant
        #23;
        chk("rst_grant", bus.grant, 0);
        chk("rst_blank", bus.blank, 1);
        chk("rst_disp", bus.displayed_number, 0);
        chk("rst_state", bus.state_dbg, 0);
        rst = 1'b1;
        model_reset();
        repeat (20) step();
        set_val(0, 14'd1540);
        bus.req = 4'b0001;
        step();
        chk("first_grant", bus.grant, 4'b0001);
        chk("first_disp", bus.displayed_number, 1540);
        chk("first_blank", bus.blank, 0);

        // Round-robin dwell: every complete hold is HOLD cycles, requester 2 skipped
        set_val(1, 14'd77);
        set_val(2, 14'd5555);
        set_val(3, 14'd12000);
        bus.req = 4'b1011;
        exp_q = {4'b0010, 4'b1000, 4'b0001, 4'b0010};
        run  = 1;
        prev = bus.grant;
        repeat (32) begin
            step();
            if (bus.grant === prev) run++;
            else begin
                chk("rr_run", run, HOLD);
                chk("rr_order", bus.grant, (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000);
                prev = bus.grant;
                run  = 1;
            end
        end
        chk("rr_all_seen", exp_q.size(), 0);

        // next_pulse at dwell 3, then on the expiry cycle
        bus.req = 4'b0011;
        wait_grant("np_wait", 4'b0001, 20);
        repeat (3) step();
        bus.next_pulse = 1'b1;
        step();
        bus.next_pulse = 1'b0;
        chk("np_grant", bus.grant, 4'b0010);
        repeat (HOLD - 1) begin
            step();
            chk("np_hold", bus.grant, 4'b0010);
        end
        step();
        chk("np_expire", bus.grant, 4'b0001);
        repeat (HOLD - 1) step();
        bus.next_pulse = 1'b1;
        step();
        bus.next_pulse = 1'b0;
        chk("np_coinc", bus.grant, 4'b0010);
        step();
        chk("np_single", bus.grant, 4'b0010);

        // Sole requester, drop to idle, drop with direct handoff
        bus.req = 4'b0100;
        step();
        chk("sole_grant", bus.grant, 4'b0100);
        repeat (20) begin
            step();
            chk("sole_hold", bus.grant, 4'b0100);
        end
        bus.req = 4'b0000;
        step();
        chk("drop_grant", bus.grant, 0);
        chk("drop_blank", bus.blank, 1);
        chk("drop_disp", bus.displayed_number, 0);
        bus.req = 4'b0100;
        step();
        bus.req = 4'b1100;
        repeat (3) step();
        chk("pre_handoff", bus.grant, 4'b0100);
        bus.req = 4'b1000;
        step();
        chk("drop_handoff", bus.grant, 4'b1000);

        // Saturation on owner 3
        set_val(3, 14'd16383);
        step();
        chk("sat_16383", bus.displayed_number, 9999);
        chk("ovf_16383", bus.ovf, 1);
        set_val(3, 14'd10000);
        step();
        chk("sat_10000", bus.displayed_number, 9999);
        chk("ovf_10000", bus.ovf, 1);
        set_val(3, 14'd9999);
        step();
        chk("sat_9999", bus.displayed_number, 9999);
        chk("ovf_9999", bus.ovf, 0);
        set_val(3, 14'd42);
        chk("val_lag", bus.displayed_number, 9999);
        step();
        chk("val_42", bus.displayed_number, 42);

        // Asynchronous reset at owner 2, dwell 5
        bus.req = 4'b0100;
        step();
        chk("mid_owner", bus.grant, 4'b0100);
        repeat (5) step();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_grant", bus.grant, 0);
        chk("arst_disp", bus.displayed_number, 0);
        chk("arst_blank", bus.blank, 1);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_state", bus.state_dbg, 0);
        bus.req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_grant", bus.grant, 4'b0001);

        // Random traffic against the model
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.next_pulse = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) set_val(i, 14'($urandom_range(0, 16383)));
            end
            step();
        end
        bus.next_pulse = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the single 4-digit seven-segment display datapath between up to NUM_REQ value sources (counters, status words, debug values). It grants one requester at a time in round-robin order. Each grant holds for a fixed dwell time, or until a debounced "next" button pulse or a request drop. It drives the 14-bit binary number consumed by the display decoder, blanks the display when nobody requests it, and saturates values above 9999.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- HOLD_CYCLES, 100000000: dwell time per grant, in clk cycles (≥2).
- CNT_WIDTH, 27: dwell counter width; must hold HOLD_CYCLES-1.

- clk  in  1  system clock (100 MHz board clock).
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-source request level; held high while the source wants the display.
- value  in  NUM_REQ*14  packed binary values; source i occupies bits [14*i+13:14*i].
- next_pulse  in  1  single-cycle advance strobe, synchronous to clk (from button debouncer).
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- displayed_number  out  14  value for the display decoder, 0..9999.
- blank  out  1  high when no owner; decoder/top uses it to turn segments off.
- ovf  out  1  high while the owner's raw value exceeds 9999.

## Operation
- FSM with two states: IDLE and SHOW. All outputs are registered.
- Round-robin pointer ptr (index of last owner) resets to NUM_REQ-1, so requester 0 wins first.
- Search rule: the winner is the first i with req[i]=1, scanning ptr+1, ptr+2, … with wrap-around modulo NUM_REQ. The current owner is considered last.
- IDLE: if any req is high, go to SHOW, grant the winner, set ptr to the winner, clear the dwell counter and deassert blank.
- SHOW, each cycle, priority order:
  1. Owner's req low: re-arbitrate immediately. If another requester exists, hand off directly. Otherwise go to IDLE with grant=0 and blank=1.
  2. next_pulse=1 or dwell counter = HOLD_CYCLES-1: re-arbitrate. If the owner is the sole requester, keep it. Either way the dwell counter clears.
  3. Otherwise increment the dwell counter.
- Coincident events (drop + next_pulse, next_pulse + expiry) cause exactly one advance, never a skip of two.
- Handoff is gapless: grant switches from the old owner to the new owner on one edge, with no all-zero cycle.
- displayed_number is registered from the granted slice, following live updates of that value:
  - raw > 9999: output 9999 (decimal) and set ovf=1.
  - otherwise: output raw and set ovf=0.
  - In IDLE: displayed_number=0 and ovf=0.
- Requests from non-owners never disturb the current grant until a re-arbitration event.
- Reset (asserted at any time, including mid-dwell): IDLE, grant=0, displayed_number=0, blank=1, ovf=0, dwell counter=0, ptr=NUM_REQ-1. Operation resumes on the first clk edge after release.

## Timing
- Request to grant: req[i] rising in IDLE gives grant[i] on the next edge, 1 cycle.
- Grant to display: displayed_number and ovf reflect the new owner on the same edge as grant. Afterwards they track value changes with 1-cycle latency.
- Dwell: an uninterrupted owner with competitors holds grant for exactly HOLD_CYCLES cycles.
- next_pulse: grant moves on the edge following the pulse cycle. The next owner then receives a full HOLD_CYCLES dwell.
- Drop: req low in cycle n gives the new grant, or IDLE, at edge n+1.
- blank equals (state==IDLE), registered. It rises on the same edge grant goes to zero.

## Test plan
All scenarios use NUM_REQ=4, HOLD_CYCLES=8.

- **Reset and first grant:** hold rst low, then release with req=0000. Require blank=1, grant=0000 and displayed_number=0 for 20 cycles. Then raise req=0001 with value0=1540. Require grant=0001 and displayed_number=1540 after 1 cycle, blank=0.
- **Round-robin dwell:** req=1011. Require grant sequence 0001→0010→1000→0001, each held exactly 8 cycles; requester 2 is never granted.
- **next_pulse:** req=0011 with owner 0 at dwell cycle 3. Pulse next_pulse for 1 cycle. Require grant=0010 on the next edge and a fresh 8-cycle dwell. Also pulse on the expiry cycle and require a single advance.
- **Sole requester and drop:** req=0100. Require grant=0100 held indefinitely; expiry causes no gap. Drop req to 0000 and require grant=0000, blank=1 and displayed_number=0 one cycle later. Also drop the owner while req[3]=1 and require a direct handoff to 1000.
- **Saturation:** owner value 16383, then 10000, then 9999. Require displayed_number=9999 with ovf=1,1,0 respectively. A value change to 42 appears one cycle later.
- **Mid-dwell reset:** assert rst asynchronously at owner 2, dwell 5, away from a clk edge. Require all outputs at reset values immediately. After release with req=1111, require the first grant to be 0001.
